debounce_bank: RTL
==================

# debounce_bank

Parametrised multi-channel debouncer that replaces the single-channel, fixed-count debouncer used for the pushbuttons. It synchronises N asynchronous inputs (buttons, switches, PMOD lines) into the 65 MHz system clock. Per channel it produces a debounced level, one-cycle press/release pulses, a long-press pulse, and an optional auto-repeat pulse train. It sits directly behind the board pins and feeds reset, transmit-trigger and cursor/move logic.

## Interface
- N_CH, 4: number of independent channels.
- DB_COUNT, 1_000_000: consecutive stable cycles required before the clean level changes; must be ≥ 1.
- HOLD_COUNT, 65_000_000: cycles of continuous clean-high, counted from the rise, before long_out fires; must exceed REPEAT_COUNT.
- REPEAT_COUNT, 6_500_000: interval in cycles between auto-repeat pulses after HOLD_COUNT.
- REPEAT_EN, 1: 1 enables the auto-repeat pulse train on rpt_out; 0 makes rpt_out identical to rise_out.
- clk_in, input, 1: system clock (65 MHz).
- rst_in, input, 1: reset, asynchronous and active-high.
- noisy_in, input, N_CH: raw asynchronous inputs.
- clean_out, output, N_CH: debounced levels.
- rise_out, output, N_CH: one-cycle pulse when clean_out goes 0→1.
- fall_out, output, N_CH: one-cycle pulse when clean_out goes 1→0.
- long_out, output, N_CH: one-cycle pulse after HOLD_COUNT cycles held high.
- rpt_out, output, N_CH: pulse on rise, then every REPEAT_COUNT cycles once the hold threshold is reached.

## Operation
- Reset clears everything: synchroniser flops, candidate, counters, all outputs = 0. Reset does not sample noisy_in, which differs from the legacy block.
  - If an input is high at reset release, it debounces normally and produces a rise_out pulse.
- Per channel, a 2-flop synchroniser (s1→s2) feeds a candidate register cand and a counter db_cnt, width $clog2(DB_COUNT+1).
- Debounce rule, in priority order:
  - s2 ≠ cand: cand←s2, db_cnt←0.
  - Else if db_cnt == DB_COUNT: clean←cand.
  - Else: db_cnt←db_cnt+1.
  - db_cnt saturates at DB_COUNT and never wraps.
- Edge pulses are registered in the same edge that updates clean:
  - rise_out = 1 iff clean changes 0→1.
  - fall_out = 1 iff clean changes 1→0.
  - They are never both high on one channel.
- Hold counter hold_cnt, width $clog2(HOLD_COUNT+1):
  - Cleared whenever clean is 0 or on a rise.
  - Increments while clean is 1 and saturates at HOLD_COUNT.
  - long_out pulses on the cycle hold_cnt transitions to HOLD_COUNT, exactly once per press.
- Repeat counter rpt_cnt:
  - Held at 0 until hold_cnt reaches HOLD_COUNT.
  - Then counts 0..REPEAT_COUNT-1 and wraps; rpt_out pulses on each wrap.
  - The first repeat pulse coincides with long_out.
  - rpt_out also pulses with rise_out.
- Release at any point:
  - fall_out pulses.
  - hold_cnt and rpt_cnt clear in the same edge.
  - No further long/rpt pulses.
- Glitch shorter than DB_COUNT+1 stable cycles: no change on clean or on any pulse output.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- Latency: for a raw step first captured by s1 at edge k (and then held stable), clean/rise/fall update at edge k+DB_COUNT+3 (2 sync + 1 cand + DB_COUNT count + 1 update).
- long_out fires HOLD_COUNT cycles after rise_out.
- Subsequent rpt_out pulses fire every REPEAT_COUNT cycles after long_out.
- All outputs are registered. There are no combinational paths from noisy_in.
- Asynchronous reset mid-count aborts all counters immediately. Pulses in flight are dropped.

## Structure
- No shared package. Parameters are local to this block.
- One natural sub-module: debounce_chan (one channel: synchroniser, debounce, hold/repeat logic). It is instantiated N_CH times in a generate loop.
- debounce_bank holds only the generate loop and bus packing.

## Test plan
Bench parameters: DB_COUNT=4, HOLD_COUNT=20, REPEAT_COUNT=8, N_CH=2.
- Reset, then a clean step on ch0 at edge 10 → clean_out[0] and a one-cycle rise_out[0] at edge 17; ch1 stays 0 throughout.
- A 3-cycle high glitch, then a 4-cycle high glitch on ch0 → no change on any output.
- Hold ch0 high for 50 cycles after rise (at edge 17):
  - long_out[0] at edge 37.
  - rpt_out[0] at edges 17, 37, 45, 53, …
- Same hold with REPEAT_EN=0 → rpt_out[0] only at edge 17.
- Release ch0 at edge 40 → fall_out[0] at edge 47, with no rpt_out at edge 45 or later; clean_out[0]=0.
- Both channels step simultaneously → rise_out=2'b11 in the same cycle.
- Assert rst_in asynchronously (mid-cycle) mid-debounce → all outputs 0 immediately. After release with the input still high → rise 7 cycles after the first sampling edge.

Source files
------------

// File: rtl/debounce_chan.sv
// Single debounce channel: 2-flop synchroniser, stable-count debounce, edge pulses,
// long-press detection and optional auto-repeat pulse train.
module debounce_chan #(
    parameter int unsigned DB_COUNT     = 1_000_000,
    parameter int unsigned HOLD_COUNT   = 65_000_000,
    parameter int unsigned REPEAT_COUNT = 6_500_000,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic noisy_in,
    output logic clean_out,
    output logic rise_out,
    output logic fall_out,
    output logic long_out,
    output logic rpt_out
);

    localparam int unsigned DB_W   = $clog2(DB_COUNT + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_COUNT + 1);
    localparam int unsigned RPT_W  = $clog2(REPEAT_COUNT + 1);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_COUNT - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(REPEAT_COUNT - 1);

    logic s1_q;
    logic s2_q;
    logic cand_q, cand_d;
    logic clean_q, clean_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;
    logic long_q, long_d;
    logic rpt_q, rpt_d;
    logic wrap;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= noisy_in;
            s2_q <= s1_q;
        end
    end

    // Any disagreement restarts the stability count; a saturated count commits cand.
    always_comb begin
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        clean_d  = clean_q;
        if (s2_q != cand_q) begin
            cand_d   = s2_q;
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            clean_d = cand_q;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    // Keyed on clean_d so a release clears the counters in the same edge as fall.
    always_comb begin
        hold_d    = hold_q;
        rpt_cnt_d = rpt_cnt_q;
        long_d    = 1'b0;
        wrap      = 1'b0;
        if (!clean_d || rise_d) begin
            hold_d    = '0;
            rpt_cnt_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
            long_d = (hold_q == HOLD_PRE);
        end else if (rpt_cnt_q == RPT_LAST) begin
            rpt_cnt_d = '0;
            wrap      = 1'b1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
    end

    always_comb begin
        if (REPEAT_EN) begin
            rpt_d = rise_d | long_d | wrap;
        end else begin
            rpt_d = rise_d;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cand_q    <= 1'b0;
            clean_q   <= 1'b0;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            rpt_cnt_q <= '0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            clean_q   <= clean_d;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            rpt_cnt_q <= rpt_cnt_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            long_q    <= long_d;
            rpt_q     <= rpt_d;
        end
    end

    assign clean_out = clean_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;
    assign long_out  = long_q;
    assign rpt_out   = rpt_q;

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels packed onto bus-wide ports.
module debounce_bank #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DB_COUNT     = 1_000_000,
    parameter int unsigned HOLD_COUNT   = 65_000_000,
    parameter int unsigned REPEAT_COUNT = 6_500_000,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [N_CH-1:0] noisy_in,
    output logic [N_CH-1:0] clean_out,
    output logic [N_CH-1:0] rise_out,
    output logic [N_CH-1:0] fall_out,
    output logic [N_CH-1:0] long_out,
    output logic [N_CH-1:0] rpt_out
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        debounce_chan #(
            .DB_COUNT     (DB_COUNT),
            .HOLD_COUNT   (HOLD_COUNT),
            .REPEAT_COUNT (REPEAT_COUNT),
            .REPEAT_EN    (REPEAT_EN)
        ) u_chan (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .noisy_in  (noisy_in[i]),
            .clean_out (clean_out[i]),
            .rise_out  (rise_out[i]),
            .fall_out  (fall_out[i]),
            .long_out  (long_out[i]),
            .rpt_out   (rpt_out[i])
        );
    end

endmodule
